// File: rtl/tof_pkg.sv
// Shared ToF constants: sample layout, field offsets and the rotating-priority helper.
// Honours TOF_TIMESTAMP_EN, which widens the host word by a 16-bit timestamp above the sample.
package tof_pkg;

    localparam int NB_OF_SENSORS = 8;
    localparam int TOF_IDX_W     = 3;
    localparam int TOF_SAMPLE_W  = 22;
    localparam int TOF_DIST_W    = 16;
    localparam int TOF_SIDX_W    = 6;
    localparam int TOF_TS_W      = 16;

    localparam int TOF_DIST_LSB  = 0;
    localparam int TOF_SIDX_LSB  = TOF_DIST_LSB + TOF_DIST_W;

`ifdef TOF_TIMESTAMP_EN
    localparam bit TOF_TS_EN     = 1'b1;
`else
    localparam bit TOF_TS_EN     = 1'b0;
`endif
    localparam int TOF_WORD_W    = TOF_SAMPLE_W + (TOF_TS_EN ? TOF_TS_W : 0);

    // First set flag after idx in rotating order; idx itself when no other flag is set.
    // Scans farthest-first so the nearest candidate is the last one assigned.
    function automatic logic [TOF_IDX_W-1:0] next_index(
        input logic [NB_OF_SENSORS-1:0] flags,
        input logic [TOF_IDX_W-1:0]     idx
    );
        logic [TOF_IDX_W-1:0] cand;
        next_index = idx;
        for (int k = NB_OF_SENSORS - 1; k >= 1; k--) begin
            cand = idx + TOF_IDX_W'(k);
            if (flags[cand]) next_index = cand;
        end
    endfunction

endpackage

// File: rtl/tof_sample_fifo.sv
// Synchronous first-word-fall-through FIFO: the head is presented whenever the FIFO is non-empty.
// A push on a full FIFO is accepted only together with a pop; a pop on empty is ignored.
module tof_sample_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: storage is deliberately not reset; the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/tof_readout_arbiter.sv
// Round-robin readout of the 8 ToF sticky flags into a sample FIFO drained over a valid/ready stream.
// TOF_TIMESTAMP_EN prepends a free-running 16-bit cycle count, sampled at push, to each word.
module tof_readout_arbiter
    import tof_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NB_OF_SENSORS-1:0]    tof_ready_in,
    input  logic [TOF_SAMPLE_W-1:0]     tof_data_in,
    output logic [TOF_IDX_W-1:0]        tof_index_out,
    output logic [TOF_WORD_W-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic [OVF_CNT_W-1:0]        overflow_count
);

    logic [TOF_IDX_W-1:0]  r_idx;
    logic                  r_overflow;
    logic [OVF_CNT_W-1:0]  r_ovf_cnt;
    logic [TOF_IDX_W-1:0]  w_idx_next;
    logic                  w_hit;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [TOF_WORD_W-1:0] w_word;

    // Selecting a sensor consumes its flag, so every hit is either pushed or counted as a drop.
    assign w_hit  = enable & tof_ready_in[r_idx];
    assign w_pop  = ~w_empty & m_ready;
    assign w_push = w_hit & (~w_full | w_pop);
    assign w_drop = w_hit & w_full & ~w_pop;

    // NOTE: the default comes first so every path assigns w_idx_next and no latch is inferred.
    always_comb begin
        w_idx_next = r_idx;
        if (enable) w_idx_next = next_index(tof_ready_in, r_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else begin
            r_idx <= w_idx_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_ovf_cnt != {OVF_CNT_W{1'b1}}) r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end

`ifdef TOF_TIMESTAMP_EN
    logic [TOF_TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + TOF_TS_W'(1);
    end

    assign w_word = {r_ts,
                     tof_data_in[TOF_SIDX_LSB +: TOF_SIDX_W],
                     tof_data_in[TOF_DIST_LSB +: TOF_DIST_W]};
`else
    assign w_word = {tof_data_in[TOF_SIDX_LSB +: TOF_SIDX_W],
                     tof_data_in[TOF_DIST_LSB +: TOF_DIST_W]};
`endif

    tof_sample_fifo #(
        .WIDTH (TOF_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .o_head      (m_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign tof_index_out  = r_idx;
    assign m_valid        = ~w_empty;
    assign overflow       = r_overflow;
    assign overflow_count = r_ovf_cnt;

endmodule

// File: tb/tb_tof_readout_arbiter.sv
// Scoreboard bench for tof_readout_arbiter with a behavioural model of the comm block's sticky flags.
// Under TOF_TIMESTAMP_EN it also checks the timestamp field, including the 16'hFFFF->0 wrap.
module tb_tof_readout_arbiter;
    import tof_pkg::*;

    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic [7:0]              tof_ready_in = '0;
    logic [7:0]              pulse;
    logic [TOF_SAMPLE_W-1:0] tof_data_in;
    logic [TOF_SAMPLE_W-1:0] data_table [8];
    logic [TOF_IDX_W-1:0]    tof_index_out;
    logic [TOF_WORD_W-1:0]   m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [LVL_W-1:0]        fifo_level;
    logic                    overflow;
    logic [7:0]              overflow_count;
    logic [15:0]             tb_cyc = '0;

    typedef struct {
        logic [TOF_WORD_W-1:0] data;
        bit                    ts_known;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tof_readout_arbiter #(.FIFO_DEPTH(DEPTH), .OVF_CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .tof_ready_in   (tof_ready_in),
        .tof_data_in    (tof_data_in),
        .tof_index_out  (tof_index_out),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .overflow_count (overflow_count)
    );

    // Comm block: a pulse sets the flag; a selected flag without a pulse clears on the edge.
    assign tof_data_in = data_table[tof_index_out];
    always @(posedge clk) begin
        for (int n = 0; n < 8; n++) begin
            if (pulse[n])                               tof_ready_in[n] <= 1'b1;
            else if (TOF_IDX_W'(n) == tof_index_out)    tof_ready_in[n] <= 1'b0;
        end
        tb_cyc <= reset ? 16'd0 : tb_cyc + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_sample(input logic [TOF_SAMPLE_W-1:0] d);
        exp_q.push_back('{data: TOF_WORD_W'(d), ts_known: 1'b0});
    endtask

    task automatic do_reset();
        m_ready = 1'b0;
        pulse   = '0;
        reset   = 1'b1;
        tick(2);
        reset   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_idx"},      64'(tof_index_out),  64'd0);
        check({tag, "_m_valid"},  64'(m_valid),        64'd0);
        check({tag, "_level"},    64'(fifo_level),     64'd0);
        check({tag, "_overflow"}, 64'(overflow),       64'd0);
        check({tag, "_ovf_cnt"},  64'(overflow_count), 64'd0);
    endtask

    // One-cycle flag pulse, then idle long enough for a parked arbiter to consume it.
    task automatic raise(input logic [7:0] mask);
        pulse = mask;
        tick(1);
        pulse = '0;
        tick(2);
    endtask

    task automatic drain();
        int k = 0;
        m_ready = 1'b1;
        while (fifo_level != '0 && k < 64) begin
            tick(1);
            k++;
        end
        check("drain_level", 64'(fifo_level), 64'd0);
        m_ready = 1'b0;
    endtask

    // Monitor: every accepted head is compared against the oldest expected sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no sample", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ts_known)
                        check("m_data_ts", 64'(m_data), 64'(e.data));
                    else
                        check("m_data", 64'(m_data[TOF_SAMPLE_W-1:0]),
                              64'(e.data[TOF_SAMPLE_W-1:0]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        pulse   = '0;
        for (int n = 0; n < 8; n++) data_table[n] = {6'(n), 16'h0100 + 16'(n)};

        // 1: reset state, idle scan holds idx
        do_reset();
        enable = 1'b1;
        check_reset_state("t1");
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t1_idx_hold", 64'(tof_index_out), 64'd0);
        end

        // 2: s2 and s5 drained back to back, then wrap from 5 to s6 and s1
        data_table[2] = {6'd2, 16'h0222};
        data_table[5] = {6'd5, 16'h0555};
        expect_sample({6'd2, 16'h0222});
        expect_sample({6'd5, 16'h0555});
        pulse = 8'b0010_0100;
        tick(1);
        pulse = '0;
        check("t2_idx_a", 64'(tof_index_out), 64'd0);
        tick(1);
        check("t2_idx_b", 64'(tof_index_out), 64'd2);
        tick(1);
        check("t2_idx_c", 64'(tof_index_out), 64'd5);
        check("t2_level_1", 64'(fifo_level), 64'd1);
        check("t2_valid", 64'(m_valid), 64'd1);
        tick(1);
        check("t2_level_2", 64'(fifo_level), 64'd2);
        data_table[6] = {6'd6, 16'h0666};
        data_table[1] = {6'd1, 16'h0111};
        expect_sample({6'd6, 16'h0666});
        expect_sample({6'd1, 16'h0111});
        pulse = 8'b0100_0010;
        tick(1);
        pulse = '0;
        tick(1);
        check("t2_idx_wrap_a", 64'(tof_index_out), 64'd6);
        tick(1);
        check("t2_idx_wrap_b", 64'(tof_index_out), 64'd1);
        tick(1);
        check("t2_level_4", 64'(fifo_level), 64'd4);
        drain();

        // 3: fill to depth, one drop, then push+pop while full
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data_table[3] = {6'd3, 16'h3000 + 16'(i)};
            if (i < 16) expect_sample({6'd3, 16'h3000 + 16'(i)});
            if (i == 16) check("t3_no_ovf_at_full", 64'(overflow), 64'd0);
            raise(8'h08);
        end
        check("t3_level_full", 64'(fifo_level), 64'd16);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_ovf_cnt", 64'(overflow_count), 64'd1);

        // 5a: enable low with a flag on idx: consumed, neither pushed nor counted
        enable = 1'b0;
        raise(8'h08);
        check("t5_dis_ovf_cnt", 64'(overflow_count), 64'd1);
        check("t5_dis_level", 64'(fifo_level), 64'd16);
        enable = 1'b1;

        data_table[3] = {6'd3, 16'h3AAA};
        expect_sample({6'd3, 16'h3AAA});
        pulse = 8'h08;
        tick(1);
        pulse   = '0;
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(1);
        check("t3_pushpop_level", 64'(fifo_level), 64'd16);
        check("t3_pushpop_ovf_cnt", 64'(overflow_count), 64'd1);
        drain();

        // 4: saturating drop counter, then reset mid-stream
        do_reset();
        enable = 1'b1;
        data_table[3] = {6'd3, 16'h4444};
        for (int i = 0; i < 16; i++) expect_sample({6'd3, 16'h4444});
        pulse = 8'h08;
        tick(300);
        pulse = '0;
        tick(2);
        check("t4_ovf_cnt_sat", 64'(overflow_count), 64'hFF);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_level", 64'(fifo_level), 64'd16);
        m_ready = 1'b1;
        tick(4);
        m_ready = 1'b0;
        check("t4_level_after_pops", 64'(fifo_level), 64'd12);
        do_reset();
        check_reset_state("t4_midreset");

        // 5b: flag on idx while disabled is lost; s7 captured once enabled
        enable = 1'b0;
        raise(8'h01);
        check("t5_dis_no_push", 64'(fifo_level), 64'd0);
        check("t5_dis_idx", 64'(tof_index_out), 64'd0);
        enable = 1'b1;
        tick(2);
        check("t5_lost_flag", 64'(fifo_level), 64'd0);
        data_table[7] = {6'd7, 16'h0777};
        expect_sample({6'd7, 16'h0777});
        pulse = 8'h80;
        tick(1);
        pulse = '0;
        begin
            int k = 0;
            while (fifo_level == '0 && k < 8) begin
                tick(1);
                k++;
            end
            check("t5_s7_latency_ok", 64'(k <= 2), 64'd1);
        end
        check("t5_s7_idx", 64'(tof_index_out), 64'd7);
        drain();

`ifdef TOF_TIMESTAMP_EN
        // 6: timestamps at cycles 10 and 13, and across the wrap
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        data_table[0] = {6'd0, 16'h0ABC};
        exp_q.push_back('{data: {16'd10, 6'd0, 16'h0ABC}, ts_known: 1'b1});
        exp_q.push_back('{data: {16'd13, 6'd0, 16'h0ABC}, ts_known: 1'b1});
        exp_q.push_back('{data: {16'hFFFF, 6'd0, 16'h0ABC}, ts_known: 1'b1});
        exp_q.push_back('{data: {16'h0000, 6'd0, 16'h0ABC}, ts_known: 1'b1});
        while (tb_cyc != 16'd9) tick(1);
        raise(8'h01);
        while (tb_cyc != 16'd12) tick(1);
        raise(8'h01);
        while (tb_cyc != 16'hFFFE) tick(1);
        pulse = 8'h01;
        tick(2);
        pulse = '0;
        tick(3);
        drain();
`endif

        tick(2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
